// File: rtl/execute_feedback_arbiter_if.sv
// ---------------------------------------------------------------------------
// execute_feedback_arbiter_if
//   Bundles the execute-unit feedback inputs and the registered wakeup/bypass
//   feedback channels of execute_feedback_arbiter.
//
//   flush        pipeline flush (synchronous)
//   unit_valid   per-unit feedback present
//   unit_phy_id  per-unit destination physical register
//   unit_value   per-unit result value
//   unit_ready   per-unit FIFO can accept this cycle
//   out_enable   per-channel valid feedback
//   out_phy_id   per-channel physical register id
//   out_value    per-channel value
//   out_src      per-channel producing unit index
//
//   master: the side that drives the units' feedback (execute stage)
//   slave : the arbiter itself
// ---------------------------------------------------------------------------
interface execute_feedback_arbiter_if #(
  parameter int UNIT_NUM         = 8,
  parameter int OUT_NUM          = 4,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int DATA_WIDTH       = 32
);
  localparam int SRC_W = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;

  logic                                            flush;
  logic [UNIT_NUM-1:0]                             unit_valid;
  logic [UNIT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]       unit_phy_id;
  logic [UNIT_NUM-1:0][DATA_WIDTH-1:0]             unit_value;
  logic [UNIT_NUM-1:0]                             unit_ready;
  logic [OUT_NUM-1:0]                              out_enable;
  logic [OUT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]        out_phy_id;
  logic [OUT_NUM-1:0][DATA_WIDTH-1:0]              out_value;
  logic [OUT_NUM-1:0][SRC_W-1:0]                   out_src;

  modport master (
    output flush, unit_valid, unit_phy_id, unit_value,
    input  unit_ready, out_enable, out_phy_id, out_value, out_src
  );

  modport slave (
    input  flush, unit_valid, unit_phy_id, unit_value,
    output unit_ready, out_enable, out_phy_id, out_value, out_src
  );
endinterface

// File: rtl/execute_feedback_arbiter.sv
// ---------------------------------------------------------------------------
// execute_feedback_arbiter
//   Collects writeback feedback from UNIT_NUM execute units into per-unit
//   FIFOs and forwards up to OUT_NUM entries per cycle onto registered
//   feedback channels, picking units round-robin.
//
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : execute_feedback_arbiter_if.slave (flush, unit_* inputs,
//          unit_ready, out_* registered channel outputs)
// ---------------------------------------------------------------------------
module execute_feedback_arbiter #(
  parameter int UNIT_NUM         = 8,
  parameter int OUT_NUM          = 4,
  parameter int FIFO_DEPTH       = 2,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  execute_feedback_arbiter_if.slave bus
);
  localparam int SRC_W   = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = PHY_REG_ID_WIDTH + DATA_WIDTH;

  logic [UNIT_NUM-1:0]              push;
  logic [UNIT_NUM-1:0]              pop;
  logic [UNIT_NUM-1:0]              nonempty;
  logic [UNIT_NUM-1:0]              ready;
  logic [UNIT_NUM-1:0][ENTRY_W-1:0] head_entry;

  // -------------------------------------------------------------------------
  // Per-unit FIFOs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < UNIT_NUM; gi++) begin : g_fifo
      logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0]   wr_ptr_reg;
      logic [PTR_W-1:0]   rd_ptr_reg;
      logic [CNT_W-1:0]   count_reg;

      // Ready comes only from the registered count, so a same-cycle pop
      // never lets a full FIFO accept.
      assign ready[gi]      = (count_reg < CNT_W'(FIFO_DEPTH));
      assign nonempty[gi]   = (count_reg != '0);
      assign push[gi]       = bus.unit_valid[gi] && ready[gi] && !bus.flush;
      assign head_entry[gi] = mem_reg[rd_ptr_reg];

      // Storage carries no reset; stale contents are never observed because
      // the head is only used while the count is nonzero.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_reg[wr_ptr_reg] <= {bus.unit_phy_id[gi], bus.unit_value[gi]};
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (bus.flush) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          // Depth is a power of two, so pointers wrap naturally.
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign bus.unit_ready = ready;

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  logic [SRC_W-1:0]                rr_ptr_reg;
  logic [SRC_W-1:0]                rr_next;
  logic [OUT_NUM-1:0]              chan_valid_next;
  logic [OUT_NUM-1:0][SRC_W-1:0]   chan_src_next;
  logic [UNIT_NUM-1:0]             grant;
  logic [SRC_W:0]                  scan_sum;
  logic [SRC_W-1:0]                scan_idx;
  int                              grant_cnt;

  always_comb begin
    grant           = '0;
    chan_valid_next = '0;
    chan_src_next   = '0;
    rr_next         = rr_ptr_reg;
    grant_cnt       = 0;
    scan_sum        = '0;
    scan_idx        = '0;
    for (int k = 0; k < UNIT_NUM; k++) begin
      // (rr_ptr + k) mod UNIT_NUM without relying on power-of-two width
      scan_sum = {1'b0, rr_ptr_reg} + (SRC_W + 1)'(k);
      if (scan_sum >= (SRC_W + 1)'(UNIT_NUM)) begin
        scan_sum = scan_sum - (SRC_W + 1)'(UNIT_NUM);
      end
      scan_idx = scan_sum[SRC_W-1:0];
      if (nonempty[scan_idx] && (grant_cnt < OUT_NUM)) begin
        grant[scan_idx]            = 1'b1;
        chan_valid_next[grant_cnt] = 1'b1;
        chan_src_next[grant_cnt]   = scan_idx;
        rr_next = (scan_idx == SRC_W'(UNIT_NUM - 1)) ? '0 : scan_idx + 1'b1;
        grant_cnt = grant_cnt + 1;
      end
    end
  end

  // A flush cancels every pop in its cycle.
  assign pop = bus.flush ? '0 : grant;

  logic [OUT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] chan_phy_next;
  logic [OUT_NUM-1:0][DATA_WIDTH-1:0]       chan_value_next;

  always_comb begin
    chan_phy_next   = '0;
    chan_value_next = '0;
    for (int j = 0; j < OUT_NUM; j++) begin
      if (chan_valid_next[j]) begin
        {chan_phy_next[j], chan_value_next[j]} = head_entry[chan_src_next[j]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered feedback channels and round-robin pointer
  // -------------------------------------------------------------------------
  logic [OUT_NUM-1:0]                       out_enable_reg;
  logic [OUT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] out_phy_id_reg;
  logic [OUT_NUM-1:0][DATA_WIDTH-1:0]       out_value_reg;
  logic [OUT_NUM-1:0][SRC_W-1:0]            out_src_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_enable_reg <= '0;
      out_phy_id_reg <= '0;
      out_value_reg  <= '0;
      out_src_reg    <= '0;
      rr_ptr_reg     <= '0;
    end else if (bus.flush) begin
      // rr_ptr_reg deliberately holds across a flush.
      out_enable_reg <= '0;
      out_phy_id_reg <= '0;
      out_value_reg  <= '0;
      out_src_reg    <= '0;
    end else begin
      out_enable_reg <= chan_valid_next;
      out_phy_id_reg <= chan_phy_next;
      out_value_reg  <= chan_value_next;
      out_src_reg    <= chan_src_next;
      rr_ptr_reg     <= rr_next;
    end
  end

  assign bus.out_enable = out_enable_reg;
  assign bus.out_phy_id = out_phy_id_reg;
  assign bus.out_value  = out_value_reg;
  assign bus.out_src    = out_src_reg;

endmodule

// File: tb/tb_execute_feedback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_execute_feedback_arbiter
//   Directed bench for execute_feedback_arbiter (8 units, 4 channels,
//   depth 2). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_execute_feedback_arbiter;
  localparam int UNIT_NUM = 8;
  localparam int OUT_NUM  = 4;
  localparam int DEPTH    = 2;
  localparam int PW       = 6;
  localparam int DW       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_feedback_arbiter_if #(
    .UNIT_NUM(UNIT_NUM), .OUT_NUM(OUT_NUM),
    .PHY_REG_ID_WIDTH(PW), .DATA_WIDTH(DW)
  ) bus ();

  execute_feedback_arbiter #(
    .UNIT_NUM(UNIT_NUM), .OUT_NUM(OUT_NUM), .FIFO_DEPTH(DEPTH),
    .PHY_REG_ID_WIDTH(PW), .DATA_WIDTH(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    bus.flush       = 1'b0;
    bus.unit_valid  = '0;
    bus.unit_phy_id = '0;
    bus.unit_value  = '0;
  endtask

  task automatic set_unit(input int u, input logic [PW-1:0] p, input logic [DW-1:0] v);
    bus.unit_valid[u]  = 1'b1;
    bus.unit_phy_id[u] = p;
    bus.unit_value[u]  = v;
  endtask

  function automatic logic fields_nonzero();
    return |{bus.out_phy_id, bus.out_value, bus.out_src};
  endfunction

  // Saturation scoreboard
  int sent [UNIT_NUM];
  int recv [UNIT_NUM];
  int accepted = 0;
  int outs     = 0;

  task automatic observe_outputs();
    int s;
    for (int j = 0; j < OUT_NUM; j++) begin
      if (bus.out_enable[j]) begin
        s = int'(bus.out_src[j]);
        check($sformatf("sat_val u%0d #%0d", s, recv[s]), 64'(bus.out_value[j]), 64'(s * 256 + recv[s]));
        check($sformatf("sat_phy u%0d", s), 64'(bus.out_phy_id[j]), 64'(s));
        recv[s]++;
        outs++;
      end
    end
  endtask

  initial begin
    logic [UNIT_NUM-1:0] rdy;
    int bad_units;
    logic any_en;

    for (int u = 0; u < UNIT_NUM; u++) begin
      sent[u] = 0;
      recv[u] = 0;
    end
    clear_inputs();

    // ---------------- reset and idle ----------------
    repeat (2) @(negedge clk);
    check("rst_enable", 64'(bus.out_enable), 64'h0);
    check("rst_ready", 64'(bus.unit_ready), 64'hFF);
    check("rst_fields", 64'(fields_nonzero()), 64'h0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("idle%0d_enable", c), 64'(bus.out_enable), 64'h0);
      check($sformatf("idle%0d_ready", c), 64'(bus.unit_ready), 64'hFF);
      check($sformatf("idle%0d_fields", c), 64'(fields_nonzero()), 64'h0);
    end

    // ---------------- single push, two-cycle latency ----------------
    set_unit(3, 6'd5, 32'h1234);
    @(negedge clk);
    clear_inputs();
    check("single_early_enable", 64'(bus.out_enable), 64'h0);
    @(negedge clk);
    check("single_enable", 64'(bus.out_enable), 64'h1);
    check("single_phy", 64'(bus.out_phy_id[0]), 64'd5);
    check("single_value", 64'(bus.out_value[0]), 64'h1234);
    check("single_src", 64'(bus.out_src[0]), 64'd3);
    check("single_rr", 64'(dut.rr_ptr_reg), 64'd4);
    @(negedge clk);
    check("single_gone", 64'(bus.out_enable), 64'h0);

    // ---------------- round-robin wrap ----------------
    set_unit(5, 6'd1, 32'h55);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    check("wrap_setup_src", 64'(bus.out_src[0]), 64'd5);
    check("wrap_setup_rr", 64'(dut.rr_ptr_reg), 64'd6);
    set_unit(6, 6'd6, 32'h66);
    set_unit(7, 6'd7, 32'h67);
    set_unit(0, 6'd0, 32'h60);
    set_unit(1, 6'd1, 32'h61);
    set_unit(2, 6'd2, 32'h62);
    @(negedge clk);
    clear_inputs();
    check("wrap_early_enable", 64'(bus.out_enable), 64'h0);
    @(negedge clk);
    check("wrap1_enable", 64'(bus.out_enable), 64'hF);
    check("wrap1_src", 64'(bus.out_src), 64'h23E);  // ch3..ch0 = 1,0,7,6
    check("wrap1_val0", 64'(bus.out_value[0]), 64'h66);
    check("wrap1_val3", 64'(bus.out_value[3]), 64'h61);
    check("wrap1_rr", 64'(dut.rr_ptr_reg), 64'd2);
    @(negedge clk);
    check("wrap2_enable", 64'(bus.out_enable), 64'h1);
    check("wrap2_src", 64'(bus.out_src[0]), 64'd2);
    check("wrap2_val", 64'(bus.out_value[0]), 64'h62);
    @(negedge clk);
    check("wrap_done", 64'(bus.out_enable), 64'h0);

    // ---------------- saturation ----------------
    for (int cyc = 0; cyc < 10; cyc++) begin
      observe_outputs();
      for (int u = 0; u < UNIT_NUM; u++) begin
        set_unit(u, PW'(u), DW'(u * 256 + sent[u]));
      end
      rdy = bus.unit_ready;
      if (cyc == 2) check("sat_ready_low_count", 64'(UNIT_NUM - $countones(rdy)), 64'd4);
      for (int u = 0; u < UNIT_NUM; u++) begin
        if (rdy[u]) begin
          sent[u]++;
          accepted++;
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    for (int cyc = 0; cyc < 12; cyc++) begin
      observe_outputs();
      @(negedge clk);
    end
    check("sat_accepted", 64'(accepted), 64'd48);
    check("sat_outputs", 64'(outs), 64'd48);
    bad_units = 0;
    for (int u = 0; u < UNIT_NUM; u++) if (recv[u] != sent[u]) bad_units++;
    check("sat_units_balanced", 64'(bad_units), 64'd0);

    // ---------------- flush ----------------
    set_unit(1, 6'd11, 32'h111);
    set_unit(5, 6'd15, 32'h555);
    @(negedge clk);
    clear_inputs();
    bus.flush = 1'b1;
    set_unit(2, 6'd12, 32'h222);
    check("flush_cycle_enable", 64'(bus.out_enable), 64'h0);
    @(negedge clk);
    clear_inputs();
    check("flush_next_enable", 64'(bus.out_enable), 64'h0);
    check("flush_next_ready", 64'(bus.unit_ready), 64'hFF);
    any_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      any_en = any_en | (|bus.out_enable);
    end
    check("flush_nothing_leaks", 64'(any_en), 64'h0);

    // ---------------- asynchronous reset mid-operation ----------------
    set_unit(0, 6'd20, 32'hA0);
    set_unit(4, 6'd24, 32'hA4);
    @(negedge clk);
    clear_inputs();
    for (int u = 0; u < UNIT_NUM; u++) if (u != 4) set_unit(u, PW'(u), DW'(32'hB0 + u));
    @(negedge clk);
    clear_inputs();
    check("arst_pre_enable", 64'(bus.out_enable), 64'h3);
    #2 rst = 1'b1;
    #1;
    check("arst_enable", 64'(bus.out_enable), 64'h0);
    check("arst_ready", 64'(bus.unit_ready), 64'hFF);
    check("arst_fields", 64'(fields_nonzero()), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_after_enable", 64'(bus.out_enable), 64'h0);
    set_unit(7, 6'd9, 32'hABCD);
    @(negedge clk);
    clear_inputs();
    check("arst_no_stale", 64'(bus.out_enable), 64'h0);
    @(negedge clk);
    check("arst_push_enable", 64'(bus.out_enable), 64'h1);
    check("arst_push_src", 64'(bus.out_src[0]), 64'd7);
    check("arst_push_phy", 64'(bus.out_phy_id[0]), 64'd9);
    check("arst_push_value", 64'(bus.out_value[0]), 64'hABCD);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/execute_feedback_arbiter.md
# execute_feedback_arbiter

Parametrised, buffered execute-feedback collector. It accepts writeback feedback (physical register id plus value) from `UNIT_NUM` execute units and funnels it onto `OUT_NUM` registered feedback channels for wakeup and bypass. When more units report in a cycle than there are output channels, it arbitrates round-robin. Each unit has its own small FIFO and a ready signal for backpressure. It sits between the execute stage outputs and the issue-queue wakeup and bypass network.

## Interface
Parameters:
- `UNIT_NUM`, default 8: number of execute units feeding in.
- `OUT_NUM`, default 4: number of output feedback channels per cycle (1..`UNIT_NUM`).
- `FIFO_DEPTH`, default 2: entries per unit FIFO (power of two, ≥2).
- `PHY_REG_ID_WIDTH`, default 6: physical register id width.
- `DATA_WIDTH`, default 32: feedback value width.

Ports (`SRC_W` = `$clog2(UNIT_NUM)`). One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `flush`  in  1  synchronous pipeline flush.
- `unit_valid`  in  `UNIT_NUM`  unit i presents feedback.
- `unit_phy_id`  in  `UNIT_NUM`×`PHY_REG_ID_WIDTH`  destination physical register per unit.
- `unit_value`  in  `UNIT_NUM`×`DATA_WIDTH`  result value per unit.
- `unit_ready`  out  `UNIT_NUM`  unit i's FIFO can accept this cycle.
- `out_enable`  out  `OUT_NUM`  output channel j carries valid feedback.
- `out_phy_id`  out  `OUT_NUM`×`PHY_REG_ID_WIDTH`  channel j's physical register id.
- `out_value`  out  `OUT_NUM`×`DATA_WIDTH`  channel j's value.
- `out_src`  out  `OUT_NUM`×`SRC_W`  index of the unit that produced channel j.

## Operation
- Each unit has a FIFO with a write pointer, a read pointer and a count.
  - `unit_ready[i]` = (count_i < `FIFO_DEPTH`). It is purely a function of the registered count; a pop in the same cycle does not raise it.
  - A push occurs when `unit_valid[i] && unit_ready[i]`. Valid while not ready is ignored, and the unit must hold its data.
- Arbitration, combinational each cycle:
  - Scan units in order `rr_ptr`, `rr_ptr+1`, … modulo `UNIT_NUM`.
  - Grant the first `OUT_NUM` units with a nonempty FIFO.
  - The k-th granted unit (k = 0..) goes to output channel k. Its FIFO head is popped and registered into channel k.
  - Channels with no grant register `out_enable`=0. Their phy_id, value and src are registered as 0.
- Pointer update: `rr_ptr` ← (index of the last granted unit + 1) mod `UNIT_NUM`. If nothing is granted, `rr_ptr` holds.
- An entry pushed in cycle t is not eligible for arbitration until cycle t+1; there is no bypass from input to output.
- Per-unit order is preserved. There is no ordering guarantee across units.
- `flush` has priority over everything:
  - All FIFO counts and pointers clear.
  - All `out_enable` are registered 0.
  - Pushes in the flush cycle are discarded; no pops occur.
  - `rr_ptr` holds its value.
- Simultaneous push and pop on the same FIFO is legal when count < `FIFO_DEPTH`: count is unchanged and the pointers advance.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - All `out_enable`, `out_phy_id`, `out_value` and `out_src` = 0.
  - All FIFO counts = 0, so all `unit_ready` = 1.
  - `rr_ptr` = 0.
- Latency: accepted at edge E (cycle t), visible at the earliest on the outputs in cycle t+2. The FIFO write happens at edge E and the output register is loaded at the next edge.
- Throughput: up to `OUT_NUM` feedbacks per cycle; at most one pop per unit per cycle.
- The outputs are registered and there is no output backpressure: each output is valid for exactly one cycle.
- `flush` asserted in cycle t means `out_enable` = 0 and `unit_ready` = all-ones in cycle t+1.
- `rst` takes effect immediately (asynchronously), regardless of the clock, and resets all state mid-operation.

## Test plan
Parameters for all scenarios: `UNIT_NUM`=8, `OUT_NUM`=4, `FIFO_DEPTH`=2.
- Reset, then idle 5 cycles → `out_enable`=0 and `unit_ready`=8'hFF throughout; every output field stays 0.
- Unit 3 pushes phy_id=5, value=0x1234 in cycle 1 → in cycle 3, channel 0 shows enable=1, phy_id=5, value=0x1234, src=3; channels 1–3 are disabled; `rr_ptr` becomes 4.
- Round-robin wrap:
  - Setup: `rr_ptr`=6; units 6, 7, 0, 1, 2 each nonempty (one entry).
  - First output cycle: channels 0–3 = src 6, 7, 0, 1; `rr_ptr`=2.
  - Next output cycle: channel 0 = src 2, the rest disabled.
- Saturation: all 8 units hold valid every cycle for 10 cycles with per-unit incrementing values.
  - Each `unit_ready` deasserts once its count reaches 2.
  - Total outputs produced equals total handshakes accepted.
  - Every unit's values emerge in increasing order; nothing is duplicated or lost.
- Flush with 2 entries queued in units 1 and 5, plus a new push on unit 2 in the flush cycle → next cycle `out_enable`=0 and `unit_ready`=8'hFF. No flushed or discarded entry ever appears on the outputs.
- Asserting `rst` between clock edges while entries are queued → outputs and `unit_ready` take their reset values immediately, before the next edge; after release, a single push on unit 7 appears on channel 0 with src=7.
